// File: rtl/z88_mem_arbiter.sv
// z88_mem_arbiter: serialises CPU and LCD accesses onto the slot-0 ROM/SRAM pair
//
// Ports
//   clk_i, reset_i                      master clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i       CPU request (held until cpu_ack_o)
//   cpu_ack_o, cpu_rdata_o              one-cycle completion pulse, read data (held)
//   lcd_req_i/addr_i                    display fetch request, read only
//   lcd_ack_o, lcd_rdata_o              one-cycle completion pulse, fetch data (held)
//   mem_a_o, ram_di_o                   shared chip address, SRAM write data
//   ram_do_i, rom_do_i                  SRAM / ROM read data
//   ram_ce_n_o, ram_oe_n_o, ram_we_n_o  SRAM strobes, active low
//   rom_ce_n_o, rom_oe_n_o              ROM strobes, active low
//   busy_o                              high whenever an access is in progress
//
// Address bits [21:19]: 000 = ROM, 001 = RAM, anything else is unmapped
// (full sequence runs with no chip enabled, reads return 8'hFF).
module z88_mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [21:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_rdata_o,
    input  logic        lcd_req_i,
    input  logic [21:0] lcd_addr_i,
    output logic        lcd_ack_o,
    output logic [7:0]  lcd_rdata_o,
    output logic [18:0] mem_a_o,
    output logic [7:0]  ram_di_o,
    input  logic [7:0]  ram_do_i,
    input  logic [7:0]  rom_do_i,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o,
    output logic        rom_ce_n_o,
    output logic        rom_oe_n_o,
    output logic        busy_o
);
    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [21:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    // Owner of the current access; once idle it is the previous winner used
    // for round robin. Resets to LCD so the CPU wins the first contention.
    logic        last_lcd_q;
    logic        cpu_ack_q, lcd_ack_q;
    logic [7:0]  cpu_rdata_q, lcd_rdata_q;

    logic        grant, grant_lcd, last_beat, sel_rom, sel_ram, active, rd_phase;
    logic [7:0]  rd_data;

    assign sel_rom  = addr_q[21:19] == 3'b000;
    assign sel_ram  = addr_q[21:19] == 3'b001;
    assign rd_data  = sel_rom ? rom_do_i : sel_ram ? ram_do_i : 8'hFF;
    assign active   = state_q != IDLE;
    assign rd_phase = (state_q == SETUP) || (state_q == ACCESS);

    always_comb begin
        grant     = cpu_req_i || lcd_req_i;
        grant_lcd = lcd_req_i && (!cpu_req_i || !last_lcd_q);
        last_beat = (state_q == ACCESS) && (cnt_q == CW'(ACCESS_CYCLES - 1));
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE:    state_d = grant ? SETUP : IDLE;
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                state_d = last_beat ? HOLD : ACCESS;
                cnt_d   = last_beat ? cnt_q : cnt_q + CW'(1);
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            last_lcd_q  <= 1'b1;
            cpu_ack_q   <= 1'b0;
            lcd_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            lcd_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Ack is registered on the edge entering HOLD, alongside the data.
            cpu_ack_q <= last_beat && !last_lcd_q;
            lcd_ack_q <= last_beat && last_lcd_q;
            if (state_q == IDLE && grant) begin
                addr_q     <= grant_lcd ? lcd_addr_i : cpu_addr_i;
                we_q       <= !grant_lcd && cpu_we_i;
                wdata_q    <= grant_lcd ? wdata_q : cpu_wdata_i;
                last_lcd_q <= grant_lcd;
            end
            if (last_beat && !we_q) begin
                if (last_lcd_q)
                    lcd_rdata_q <= rd_data;
                else
                    cpu_rdata_q <= rd_data;
            end
        end
    end

    // Strobes decode only registered state, so no path exists from req to pins.
    assign rom_ce_n_o  = !(active && sel_rom);
    assign ram_ce_n_o  = !(active && sel_ram);
    assign rom_oe_n_o  = !(rd_phase && sel_rom && !we_q);
    assign ram_oe_n_o  = !(rd_phase && sel_ram && !we_q);
    assign ram_we_n_o  = !((state_q == ACCESS) && sel_ram && we_q);
    assign mem_a_o     = addr_q[18:0];
    assign ram_di_o    = wdata_q;
    assign busy_o      = active;
    assign cpu_ack_o   = cpu_ack_q;
    assign lcd_ack_o   = lcd_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign lcd_rdata_o = lcd_rdata_q;

endmodule

// File: tb/tb_z88_mem_arbiter.sv
// tb_z88_mem_arbiter: directed vector bench for z88_mem_arbiter
module tb_z88_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, lcd_req = 1'b0;
    logic [21:0] cpu_addr = '0, lcd_addr = '0;
    logic [7:0]  cpu_wdata = '0, rom_do = '0;
    logic        cpu_ack, lcd_ack, busy;
    logic [7:0]  cpu_rdata, lcd_rdata, ram_di, ram_do;
    logic [18:0] mem_a;
    logic        ram_ce_n, ram_oe_n, ram_we_n, rom_ce_n, rom_oe_n;
    bit   [7:0]  ram_mem [0:1023];
    int          checks = 0, errors = 0;

    typedef struct {
        bit          lcd;
        bit          we;
        logic [21:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rom;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [11];

    z88_mem_arbiter #(.ACCESS_CYCLES(2)) dut (
        .clk_i(clk), .reset_i(reset),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .lcd_req_i(lcd_req), .lcd_addr_i(lcd_addr), .lcd_ack_o(lcd_ack), .lcd_rdata_o(lcd_rdata),
        .mem_a_o(mem_a), .ram_di_o(ram_di), .ram_do_i(ram_do), .rom_do_i(rom_do),
        .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n),
        .rom_ce_n_o(rom_ce_n), .rom_oe_n_o(rom_oe_n), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Small SRAM model, aliased on the low 10 address bits.
    always @(posedge clk)
        if (!ram_ce_n && !ram_we_n) ram_mem[mem_a[9:0]] <= ram_di;
    assign ram_do = ram_mem[mem_a[9:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {rom_ce_n, rom_oe_n, ram_ce_n, ram_oe_n, ram_we_n, busy, cpu_ack, lcd_ack};
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_strobes"}, strobes(), 8'hF8);
        chk({nm, "_rdata"}, {cpu_rdata, lcd_rdata}, 16'h0000);
        chk({nm, "_mem_a"}, mem_a, 19'h0);
        chk({nm, "_ram_di"}, ram_di, 8'h00);
    endtask

    task automatic proto_chk();
        chk("one_ce", !rom_ce_n && !ram_ce_n, 0);
        chk("we_oe_overlap", !ram_we_n && !ram_oe_n, 0);
        chk("idle_strobes", !busy && ({rom_ce_n, rom_oe_n, ram_ce_n, ram_oe_n, ram_we_n} != 5'h1F), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit rom, ram, a, r, x;
        logic [7:0] exp_s;
        @(posedge clk);
        #1;
        rom_do = v.rom;
        if (v.lcd) begin
            lcd_req  = 1'b1;
            lcd_addr = v.addr;
        end else begin
            cpu_req   = 1'b1;
            cpu_we    = v.we;
            cpu_addr  = v.addr;
            cpu_wdata = v.wd;
        end
        rom = v.addr[21:19] == 3'b000;
        ram = v.addr[21:19] == 3'b001;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            a = c >= 1 && c <= 4;
            r = c >= 1 && c <= 3;
            x = c == 2 || c == 3;
            exp_s = {!(a && rom), !(r && rom && !v.we), !(a && ram), !(r && ram && !v.we),
                     !(x && ram && v.we), a, c == 4 && !v.lcd, c == 4 && v.lcd};
            chk($sformatf("v%0d_c%0d_strobes", idx, c), strobes(), exp_s);
            if (a) chk($sformatf("v%0d_c%0d_mem_a", idx, c), mem_a, v.addr[18:0]);
            if (x && ram && v.we) chk($sformatf("v%0d_c%0d_ram_di", idx, c), ram_di, v.wd);
            if (c >= 4 && !v.we)
                chk($sformatf("v%0d_c%0d_rdata", idx, c), v.lcd ? lcd_rdata : cpu_rdata, v.exp);
            if (c == 4) begin
                cpu_req = 1'b0;
                lcd_req = 1'b0;
            end
        end
    endtask

    initial begin
        int cpu_iss, cpu_done, lcd_iss, lcd_done;
        vecs[0]  = '{0, 1, 22'h08_1234, 8'hA5, 8'h00, 8'h00};
        vecs[1]  = '{0, 0, 22'h08_1234, 8'h00, 8'h00, 8'hA5};
        vecs[2]  = '{0, 0, 22'h00_0010, 8'h00, 8'h3C, 8'h3C};
        vecs[3]  = '{0, 1, 22'h00_0010, 8'h77, 8'h3C, 8'h00};
        vecs[4]  = '{1, 0, 22'h20_0000, 8'h00, 8'h3C, 8'hFF};
        vecs[5]  = '{1, 0, 22'h08_1234, 8'h00, 8'h00, 8'hA5};
        vecs[6]  = '{0, 1, 22'h0F_FFFF, 8'h42, 8'h00, 8'h00};
        vecs[7]  = '{0, 1, 22'h3F_FFFF, 8'h99, 8'h00, 8'h00};
        vecs[8]  = '{0, 0, 22'h0F_FFFF, 8'h00, 8'h11, 8'h42};
        vecs[9]  = '{1, 0, 22'h07_FFFF, 8'h00, 8'hC3, 8'hC3};
        vecs[10] = '{0, 0, 22'h10_0000, 8'h00, 8'h5A, 8'hFF};

        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // Reset during the ACCESS phase of a RAM write.
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h08_0055; cpu_wdata = 8'hEE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_access_we", {ram_we_n, ram_ce_n, busy}, 3'b001);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_strobes", {ram_we_n, ram_ce_n, busy, cpu_ack}, 4'b1100);
        cpu_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst_after");
        @(negedge clk);
        chk("midrst_no_ack", {cpu_ack, busy}, 2'b00);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Both requesters held from reset: CPU, LCD, CPU, LCD, acks 5 apart.
        @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h08_1234;
        lcd_req = 1'b1; lcd_addr = 22'h20_0000; rom_do = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            proto_chk();
            chk($sformatf("cont_c%0d_acks", c), {cpu_ack, lcd_ack},
                {c == 4 || c == 14, c == 9 || c == 19});
            if (c == 4) chk("cont_cpu_rdata", cpu_rdata, 8'hA5);
            if (c == 9) chk("cont_lcd_rdata", lcd_rdata, 8'hFF);
            if (c == 20) begin
                cpu_req = 1'b0;
                lcd_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("cont_idle", busy, 1'b0);

        // Random traffic from both requesters with protocol checking.
        cpu_iss = 0; cpu_done = 0; lcd_iss = 0; lcd_done = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            proto_chk();
            rom_do = 8'($urandom);
            if (cpu_ack) begin
                chk("cpu_ack_with_req", cpu_req, 1'b1);
                cpu_req = 1'b0;
                cpu_done++;
            end else if (!cpu_req && cyc < 400 && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = {3'($urandom_range(0, 7)), 19'($urandom)};
                cpu_wdata = 8'($urandom);
                cpu_iss++;
            end
            if (lcd_ack) begin
                chk("lcd_ack_with_req", lcd_req, 1'b1);
                lcd_req = 1'b0;
                lcd_done++;
            end else if (!lcd_req && cyc < 400 && $urandom_range(0, 2) == 0) begin
                lcd_req  = 1'b1;
                lcd_addr = {3'($urandom_range(0, 7)), 19'($urandom)};
                lcd_iss++;
            end
        end
        chk("rand_cpu_acks", cpu_done, cpu_iss);
        chk("rand_lcd_acks", lcd_done, lcd_iss);
        chk("rand_drained", {cpu_req, lcd_req, busy}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
